// File: rtl/prog_cntr_sel_ctrl_pkg.sv
// Shared fetch-stage definitions: PC-select one-hot codes, controller
// state encoding and the default program address width.
package prog_cntr_sel_ctrl_pkg;

  localparam int ADDR_WIDTH_DEF = 14;

  localparam logic [3:0] SEL_NEXT   = 4'b0001;
  localparam logic [3:0] SEL_BRANCH = 4'b0010;
  localparam logic [3:0] SEL_INT    = 4'b0100;
  localparam logic [3:0] SEL_RET    = 4'b1000;

  typedef enum logic {
    RUN = 1'b0,
    ISR = 1'b1
  } state_e;

endpackage

// File: rtl/prog_cntr_sel_ctrl_return_addr_stack.sv
// Return-address stack: register array plus depth counter. Pushes into a full
// stack and pops from an empty one leave the contents alone and set sticky flags.
module return_addr_stack #(
  parameter int AW    = 14,
  parameter int DEPTH = 8
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [AW-1:0] data_i,
  output logic [AW-1:0] top_o,
  output logic          overflow_o,
  output logic          underflow_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [AW-1:0] stack_q [DEPTH];
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          full;
  logic          empty;
  logic          do_push;
  logic          do_pop;
  logic [PW-1:0] wr_idx;
  logic [PW-1:0] top_idx;

  // push_i and pop_i are single-cycle strobes from the controller; at most one
  // is high in a cycle and each is acted on at the rising edge ending that cycle.
  assign full    = (cnt_q == CW'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign do_push = push_i && !full;
  assign do_pop  = pop_i && !empty;
  assign wr_idx  = cnt_q[PW-1:0];
  assign top_idx = wr_idx - PW'(1);
  assign top_o   = empty ? '0 : stack_q[top_idx];

  always_comb begin
    cnt_d = cnt_q;
    if (do_push) begin
      cnt_d = cnt_q + CW'(1);
    end else if (do_pop) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      cnt_q       <= '0;
      overflow_o  <= 1'b0;
      underflow_o <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      if (push_i && full) begin
        overflow_o <= 1'b1;
      end
      if (pop_i && empty) begin
        underflow_o <= 1'b1;
      end
    end
  end

  // Entries need no reset: the depth counter alone decides what is valid.
  always_ff @(posedge clock) begin
    if (reset_n && do_push) begin
      stack_q[wr_idx] <= data_i;
    end
  end

endmodule

// File: rtl/prog_cntr_sel_ctrl.sv
// Fetch-stage PC-select controller: prioritises return, branch/call, interrupt
// entry and sequential fetch, tracks ISR state and drives the return-address stack.
module prog_cntr_sel_ctrl
  import prog_cntr_sel_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int RAS_DEPTH  = 8
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  stall,
  input  logic [ADDR_WIDTH-1:0] next_prog_cntr,
  input  logic                  branch_taken,
  input  logic                  call,
  input  logic                  ret,
  input  logic                  reti,
  input  logic                  irq,
  output logic [3:0]            sel_signals,
  output logic [ADDR_WIDTH-1:0] ret_addr,
  output logic                  irq_ack,
  output logic                  in_isr,
  output logic                  ras_overflow,
  output logic                  ras_underflow
);

  state_e state_q;
  logic   push;
  logic   pop;
  logic   enter_isr;

  // Zero-latency select; a stalled cycle always fetches sequentially and
  // touches no state.
  always_comb begin
    sel_signals = SEL_NEXT;
    push        = 1'b0;
    pop         = 1'b0;
    enter_isr   = 1'b0;
    if (!stall) begin
      if (ret || reti) begin
        sel_signals = SEL_RET;
        pop         = 1'b1;
      end else if (branch_taken) begin
        sel_signals = SEL_BRANCH;
        push        = call;
      end else if (irq && (state_q == RUN)) begin
        sel_signals = SEL_INT;
        push        = 1'b1;
        enter_isr   = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= RUN;
      irq_ack <= 1'b0;
    end else begin
      irq_ack <= enter_isr;
      case (state_q)
        RUN:     if (enter_isr) state_q <= ISR;
        ISR:     if (!stall && reti) state_q <= RUN;
        default: state_q <= RUN;
      endcase
    end
  end

  assign in_isr = (state_q == ISR);

  return_addr_stack #(
    .AW    (ADDR_WIDTH),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clock       (clock),
    .reset_n     (reset_n),
    .push_i      (push),
    .pop_i       (pop),
    .data_i      (next_prog_cntr),
    .top_o       (ret_addr),
    .overflow_o  (ras_overflow),
    .underflow_o (ras_underflow)
  );

endmodule

// File: doc/prog_cntr_sel_ctrl.md
# prog_cntr_sel_ctrl

Fetch-stage controller that drives the one-hot `sel_signals` bus of the program-counter input select mux and owns the return-address stack (RAS) that supplies its `ret_addr` input. It arbitrates sequential fetch, taken branches/calls, interrupt entry and returns, and tracks interrupt-service state. It sits between decode/branch-resolution and the PC select mux in the fetch stage.

## Interface
- `ADDR_WIDTH`, 14, program address width.
- `RAS_DEPTH`, 8, return-address stack entries (power of two, ≥2).

- `clock`  in  1  system clock, rising edge.
- `reset_n`  in  1  synchronous, active-low reset.
- `stall`  in  1  fetch stall; freezes all state.
- `next_prog_cntr`  in  ADDR_WIDTH  PC+1; value pushed on call/interrupt.
- `branch_taken`  in  1  resolved taken branch/jump/call this cycle.
- `call`  in  1  qualifies `branch_taken` as a call (push).
- `ret`  in  1  subroutine return resolved (pop).
- `reti`  in  1  return-from-interrupt resolved (pop, leave ISR).
- `irq`  in  1  level interrupt request.
- `sel_signals`  out  4  one-hot select: [0] next, [1] branch, [2] interrupt vector, [3] return.
- `ret_addr`  out  ADDR_WIDTH  RAS top-of-stack; 0 when empty.
- `irq_ack`  out  1  one-cycle registered pulse after interrupt entry.
- `in_isr`  out  1  high while servicing an interrupt.
- `ras_overflow`  out  1  sticky; push attempted while full.
- `ras_underflow`  out  1  sticky; pop attempted while empty.

## Operation
- `sel_signals` is combinational from inputs and state, always exactly one-hot.
- Priority: (`ret` | `reti`) > `branch_taken` > interrupt entry > sequential.
- `stall`=1: `sel_signals`=0001; no push/pop; no interrupt acceptance; state, flags, `irq_ack` next value 0.
- States: RUN, ISR.
  - RUN: `irq`=1 with no ret/reti/branch and no stall → sel 0100, push `next_prog_cntr`, go ISR, `irq_ack`=1 next cycle.
  - ISR: `irq` ignored. `reti` → sel 1000, pop, go RUN. `ret` in ISR pops normally, stays ISR.
  - `reti` in RUN: sel 1000, pop, remain RUN (no error flag).
- `branch_taken` & `call` → sel 0010, push `next_prog_cntr`. `call` without `branch_taken` ignored.
- `ret`/`reti` with `branch_taken` same cycle: return wins, no push.
- Full push: stack contents unchanged, `ras_overflow` set. Empty pop: `ret_addr`=0, sel still 1000, `ras_underflow` set.
- Sticky flags clear only on reset.

## Timing
- Reset (`reset_n`=0 at edge): sel 0001, `ret_addr` 0, `irq_ack` 0, `in_isr` 0, both flags 0, stack depth 0. Reset mid-ISR or mid-call sequence discards all entries.
- `sel_signals` valid in the same cycle as the request; zero latency.
- Push/pop, state and `in_isr` update on the rising edge ending the request cycle; new `ret_addr` visible next cycle.
- `irq_ack` high exactly one cycle, the cycle after entry; `in_isr` rises in the same cycle.
- Back-to-back call then ret: cycle N push, cycle N+1 `ret_addr` = pushed value and pop returns it.

## Structure
- Shared fetch package: `ADDR_WIDTH` default, one-hot constants SEL_NEXT=0001, SEL_BRANCH=0010, SEL_INT=0100, SEL_RET=1000, state encoding RUN/ISR.
- Sub-module `return_addr_stack`: register array, depth counter, push/pop/full/empty, top output, overflow/underflow detection. Controller holds FSM, priority logic, `irq_ack` register.

## Test plan
- Reset then idle, no inputs → sel 0001, `ret_addr` 0, all flags 0, `in_isr` 0.
- `branch_taken`+`call`, `next_prog_cntr`=0x0123; next cycle `ret`=1 → sel 0010 then 1000, `ret_addr`=0x0123 during ret cycle, empty after.
- `irq`=1 with `next_prog_cntr`=0x0200 → sel 0100, next cycle `irq_ack`=1, `in_isr`=1; `irq` held → no second entry; `reti` → sel 1000, `ret_addr`=0x0200, `in_isr` 0 next cycle.
- 9 calls with RAS_DEPTH=8 (addresses 0x10..0x18) → `ras_overflow`=1 after 9th, top stays 0x17; 9 returns → pops 0x17..0x10, 9th sets `ras_underflow`, `ret_addr`=0.
- Simultaneous `irq`, `branch_taken` and `ret` → sel 1000, no interrupt entry; same with `stall`=1 → sel 0001, no state change.
- Assert `reset_n`=0 while `in_isr`=1 with 3 entries → next cycle all outputs at reset values.
